// File: rtl/mux_ac_stream.sv
// Packet-aware N-channel stream multiplexer. The channel is locked for a whole
// packet and the selected beat passes through a single registered output stage.
module mux_ac_stream #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEL_W-1:0]       ctrl,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH-1:0]        in_last,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [SEL_W-1:0]       cur_sel,
    output logic                   busy,
    output logic                   sel_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // One extra bit so N_CH == 2**SEL_W is still representable.
    localparam logic [SEL_W:0] N_CH_EXT = (SEL_W + 1)'(N_CH);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [SEL_W-1:0]    cur_sel_r;
    logic [SEL_W-1:0]    cur_sel_nxt_s;
    logic                sel_err_r;
    logic                sel_err_nxt_s;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;
    logic                out_last_r;
    logic [N_CH-1:0]     in_ready_s;
    logic                ctrl_ok_s;
    logic                ctrl_valid_s;
    logic                sel_valid_s;
    logic                sel_last_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                accept_s;
    logic                xfer_s;

    assign ctrl_ok_s = ({1'b0, ctrl} < N_CH_EXT);
    assign accept_s  = !out_valid_r || out_ready;
    assign xfer_s    = (state_r == ST_LOCKED) && sel_valid_s && accept_s;

    // AND-OR channel lookup: requested channel's valid, locked channel's beat
    always_comb begin
        ctrl_valid_s = 1'b0;
        sel_valid_s  = 1'b0;
        sel_last_s   = 1'b0;
        sel_data_s   = '0;
        for (int i = 0; i < N_CH; i++) begin
            ctrl_valid_s = ctrl_valid_s | (in_valid[i] & (ctrl == SEL_W'(i)));
            sel_valid_s  = sel_valid_s | (in_valid[i] & (cur_sel_r == SEL_W'(i)));
            sel_last_s   = sel_last_s | (in_last[i] & (cur_sel_r == SEL_W'(i)));
            sel_data_s   = sel_data_s |
                           (in_data[i*DATA_W +: DATA_W] & {DATA_W{cur_sel_r == SEL_W'(i)}});
        end
    end

    // Next-state, channel lock, ready steering and select-error decode
    always_comb begin
        state_nxt_s   = state_r;
        cur_sel_nxt_s = cur_sel_r;
        sel_err_nxt_s = 1'b0;
        in_ready_s    = '0;
        case (state_r)
            ST_IDLE: begin
                // X/Z on ctrl falls through every branch: no lock, no error.
                if (ctrl_ok_s) begin
                    if (ctrl_valid_s) begin
                        state_nxt_s   = ST_LOCKED;
                        cur_sel_nxt_s = ctrl;
                    end else begin
                        state_nxt_s   = ST_IDLE;
                    end
                end else if (!ctrl_ok_s) begin
                    sel_err_nxt_s = 1'b1;
                end else begin
                    sel_err_nxt_s = 1'b0;
                end
            end
            ST_LOCKED: begin
                for (int i = 0; i < N_CH; i++) begin
                    in_ready_s[i] = accept_s && (cur_sel_r == SEL_W'(i));
                end
                if (xfer_s && sel_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control state: FSM, locked channel and select-error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cur_sel_r <= '0;
            sel_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cur_sel_r <= cur_sel_nxt_s;
            sel_err_r <= sel_err_nxt_s;
        end
    end

    // Output register: load on transfer, drain on handshake, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (xfer_s) begin
            out_data_r  <= sel_data_s;
            out_valid_r <= 1'b1;
            out_last_r  <= sel_last_s;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_valid_r <= out_valid_r;
            out_last_r  <= out_last_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign cur_sel   = cur_sel_r;
    assign busy      = (state_r == ST_LOCKED);
    assign sel_err   = sel_err_r;

endmodule

// File: doc/mux_ac_stream.md
Name: mux_ac_stream

Overview:
- Parametrised N-channel, W-bit packet-aware stream multiplexer. Successor to the combinational 4:1 1-bit mux.
- Adds per-channel valid/ready/last handshakes, a registered output stage, and a select lock.
- The select is held for a whole packet, so ctrl changes cannot split or corrupt a packet.
- Sits between channel sources and a single downstream stream consumer.

Parameters:
N_CH, 4, number of input channels (2..16)
DATA_W, 8, data width per channel
SEL_W, 2, ctrl width; must be at least clog2(N_CH)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
ctrl  in  SEL_W  requested channel, sampled only in IDLE
in_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  in  N_CH  per-channel valid
in_last  in  N_CH  per-channel end-of-packet flag
in_ready  out  N_CH  per-channel ready
out_data  out  DATA_W  registered output data
out_valid  out  1  registered output valid
out_last  out  1  registered output last
out_ready  in  1  downstream ready
cur_sel  out  SEL_W  locked channel index
busy  out  1  high while LOCKED
sel_err  out  1  one-cycle pulse when an out-of-range ctrl is rejected

Behaviour:
- Reset (async assert, sync release): state=IDLE, cur_sel=0, out_valid=0, out_last=0, out_data=0, sel_err=0. in_ready=0 (comb from state).
- Reset mid-packet discards any held beat. No partial-packet recovery.
- FSM IDLE:
  - in_ready all 0.
  - If ctrl<N_CH and in_valid[ctrl]=1: cur_sel<=ctrl, go to LOCKED next cycle.
  - If ctrl>=N_CH: stay IDLE, sel_err=1 for that cycle, cur_sel unchanged.
  - Otherwise stay IDLE.
- FSM LOCKED:
  - busy=1.
  - accept = (!out_valid || out_ready). Combinational, no bubble on back-to-back beats.
  - in_ready[cur_sel]=accept. All other in_ready bits are 0.
  - Beat transfers when in_valid[cur_sel] && in_ready[cur_sel]. Next cycle: out_data=selected data, out_last=selected last, out_valid=1.
  - Transfer with in_last[cur_sel]=1: go to IDLE next cycle. The output register still drains normally.
  - ctrl is ignored while LOCKED.
- Output register:
  - out_valid clears on (out_valid && out_ready) when no new beat is loaded the same cycle.
  - Simultaneous drain and load keeps out_valid=1 with the new data.
  - out_data, out_last and out_valid hold stable while out_valid && !out_ready.
- Latency: input beat to out_valid is 1 cycle. Throughput is 1 beat/cycle inside a packet.
- Packet-switch overhead: the first beat of a new packet is accepted no earlier than 1 cycle after IDLE entry.
  - Minimum gap between packets is 1 idle input cycle.
- Channel visibility: a channel with in_valid=0 is never granted. Non-selected channels see no ready and no data loss.
- ctrl X/Z in IDLE: no lock, no sel_err. Verification checks no state change.
- Width rules: cur_sel is SEL_W bits. Comparison ctrl<N_CH is unsigned.
  - N_CH=2^SEL_W makes sel_err unreachable.

Test Plan:
1. Basic path: N_CH=4, DATA_W=8, ctrl=2, ch2 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33), out_ready=1 -> out_data 0x11, 0x22, 0x33 on consecutive cycles; out_last only with 0x33; in_ready[0,1,3]=0 throughout.
2. Select lock: during the ch2 packet, ctrl switches to 0 with ch0 valid -> no ch0 beat accepted until after the ch2 last beat. cur_sel=2 until IDLE. The next packet comes from ch0.
3. Backpressure: out_ready=0 for 4 cycles mid-packet -> out_data and out_last stable, in_ready[cur_sel]=0. On release the next beat appears 1 cycle later with no loss or duplication.
4. Out-of-range select: N_CH=3, SEL_W=2, ctrl=3 in IDLE -> sel_err high exactly 1 cycle, busy=0, no in_ready asserted.
5. Reset mid-packet: assert rst after 2 of 5 beats -> out_valid=0, busy=0 and cur_sel=0 immediately (async). After release, a new packet on ch1 completes correctly.
6. Single-beat packets: alternate ctrl 0 and 3, each beat with last=1 and continuous out_ready -> one output beat every 2 cycles, correct channel data each time.
